sar_controller: RTL and testbench

SAR_CONTROLLER -- requirements
Module: sar_controller

---
 rtl/sar_controller.sv | 129 ++++++++++++
 tb/tb_sar_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_controller.sv
// 8-bit successive-approximation controller with a one-cycle HOLD after each conversion.
// Define SAR_TRACK_EN to enable the TRACK state (Ready-qualified up/down steps, Inc/Dcr pulses).
module sar_controller (
   input  logic       ClockT,
   input  logic       Reset,
   input  logic       Start,
   input  logic       CompIn,
   input  logic       Track,
   input  logic       Ready,
   output logic [7:0] SAROut,
   output logic [1:0] StateP,
   output logic       Inc,
   output logic       Dcr,
   output logic       Done,
   output logic [7:0] Result
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CONV  = 2'b01,
      TRACK = 2'b10,
      HOLD  = 2'b11
   } state_t;

   state_t     state, state_next;
   logic [7:0] sar_next, result_next;
   logic [2:0] bit_ptr, bit_next;
   logic       done_next;

`ifdef SAR_TRACK_EN
   logic inc_q, dcr_q, inc_next, dcr_next;
   assign Inc = inc_q;
   assign Dcr = dcr_q;
`else
   logic cfg_unused;
   assign cfg_unused = Track ^ Ready;
   assign Inc        = 1'b0;
   assign Dcr        = 1'b0;
`endif

   assign StateP = state;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next  = state;
      sar_next    = SAROut;
      result_next = Result;
      bit_next    = bit_ptr;
      done_next   = 1'b0;
`ifdef SAR_TRACK_EN
      inc_next    = 1'b0;
      dcr_next    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (Start) begin
               state_next = CONV;
               sar_next   = 8'h80;
               bit_next   = 3'd7;
            end
         end
         CONV: begin
            // Resolve the current trial bit, then place the next trial bit below it.
            sar_next[bit_ptr] = CompIn;
            if (bit_ptr == 3'd0) begin
               state_next  = HOLD;
               result_next = sar_next;
               done_next   = 1'b1;
               bit_next    = 3'd7;
            end else begin
               sar_next[bit_ptr - 3'd1] = 1'b1;
               bit_next                 = bit_ptr - 3'd1;
            end
         end
         HOLD: begin
`ifdef SAR_TRACK_EN
            state_next = Track ? TRACK : IDLE;
`else
            state_next = IDLE;
`endif
         end
`ifdef SAR_TRACK_EN
         TRACK: begin
            if (!Track) begin
               state_next = IDLE;
            end else if (Ready) begin
               // Saturating step: no pulse when the code is already at the rail.
               if (CompIn && SAROut != 8'hFF) begin
                  sar_next    = SAROut + 8'd1;
                  result_next = sar_next;
                  inc_next    = 1'b1;
               end else if (!CompIn && SAROut != 8'h00) begin
                  sar_next    = SAROut - 8'd1;
                  result_next = sar_next;
                  dcr_next    = 1'b1;
               end
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <=.
   always_ff @(posedge ClockT) begin
      if (Reset) begin
         state   <= IDLE;
         SAROut  <= 8'h00;
         Result  <= 8'h00;
         bit_ptr <= 3'd7;
         Done    <= 1'b0;
`ifdef SAR_TRACK_EN
         inc_q   <= 1'b0;
         dcr_q   <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         SAROut  <= sar_next;
         Result  <= result_next;
         bit_ptr <= bit_next;
         Done    <= done_next;
`ifdef SAR_TRACK_EN
         inc_q   <= inc_next;
         dcr_q   <= dcr_next;
`endif
      end
   end

endmodule

// File: tb/tb_sar_controller.sv
// Self-checking bench for sar_controller: comparator modelled from an analog code,
// expected values from a binary-search / saturating-step reference model.
module tb_sar_controller;

   logic       clk = 1'b0;
   logic       Reset, Start, CompIn, Track, Ready;
   logic [7:0] SAROut, Result;
   logic [1:0] StateP;
   logic       Inc, Dcr, Done;

   logic [7:0] analog;
   logic       comp_force0;
   logic [7:0] exp_sar, exp_res;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_inc;
   int         n_dcr;

   sar_controller dut (
      .ClockT (clk),
      .Reset  (Reset),
      .Start  (Start),
      .CompIn (CompIn),
      .Track  (Track),
      .Ready  (Ready),
      .SAROut (SAROut),
      .StateP (StateP),
      .Inc    (Inc),
      .Dcr    (Dcr),
      .Done   (Done),
      .Result (Result)
   );

   always #5 clk = ~clk;

   // Ideal comparator: analog >= DAC code, optionally forced low.
   assign CompIn = comp_force0 ? 1'b0 : (analog >= SAROut);

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full conversion from the current negedge; returns at the negedge after HOLD.
   task automatic convert(input logic [7:0] a, input logic trk);
      int         av;
      logic [7:0] trial;
      logic [1:0] exp_after;
      av     = a;
      analog = a;
      Track  = trk;
      Start  = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         trial = 8'((((av >> (8 - k)) << (8 - k))) | (128 >> k));
         check("conv_code", SAROut, trial);
         check("conv_state", StateP, 8'd1);
         check("conv_done", Done, 8'd0);
         check("conv_incdcr", {Inc, Dcr}, 8'd0);
         Start = 1'(($urandom_range(0, 1)));
         @(negedge clk);
      end
      Start = 1'b0;
      check("hold_state", StateP, 8'd3);
      check("hold_done", Done, 8'd1);
      check("hold_result", Result, a);
      check("hold_code", SAROut, a);
      check("hold_incdcr", {Inc, Dcr}, 8'd0);
      @(negedge clk);
`ifdef SAR_TRACK_EN
      exp_after = trk ? 2'b10 : 2'b00;
`else
      exp_after = 2'b00;
`endif
      check("post_hold_state", StateP, exp_after);
      check("post_hold_done", Done, 8'd0);
      check("post_hold_incdcr", {Inc, Dcr}, 8'd0);
      exp_sar = a;
      exp_res = a;
   endtask

   // One TRACK cycle: drive at negedge, predict, check at next negedge.
   task automatic track_cycle(input logic rdy, input logic [7:0] a);
      logic cmp, ei, ed;
      Ready  = rdy;
      analog = a;
      cmp    = comp_force0 ? 1'b0 : (a >= exp_sar);
      ei     = 1'b0;
      ed     = 1'b0;
      if (rdy) begin
         if (cmp && exp_sar != 8'hFF) begin
            exp_sar = exp_sar + 8'd1;
            ei      = 1'b1;
         end else if (!cmp && exp_sar != 8'h00) begin
            exp_sar = exp_sar - 8'd1;
            ed      = 1'b1;
         end
         if (ei || ed) exp_res = exp_sar;
      end
      @(negedge clk);
      check("trk_code", SAROut, exp_sar);
      check("trk_result", Result, exp_res);
      check("trk_inc", Inc, ei);
      check("trk_dcr", Dcr, ed);
      check("trk_state", StateP, 8'd2);
      check("trk_done", Done, 8'd0);
      if (Inc) n_inc++;
      if (Dcr) n_dcr++;
   endtask

   task automatic leave_track();
      Track = 1'b0;
      Ready = 1'b0;
      @(negedge clk);
      check("exit_state", StateP, 8'd0);
      check("exit_result", Result, exp_res);
      check("exit_incdcr", {Inc, Dcr}, 8'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_done;
      Reset = 1'b1; Start = 1'b1; Track = 1'b1; Ready = 1'b1;
      analog = 8'h00; comp_force0 = 1'b0;

      // Reset dominates Start/Track/Ready.
      @(negedge clk);
      @(negedge clk);
      check("rst_state", StateP, 8'd0);
      check("rst_code", SAROut, 8'h00);
      check("rst_result", Result, 8'h00);
      check("rst_flags", {Inc, Dcr, Done}, 8'd0);
      Reset = 1'b0; Start = 1'b0; Track = 1'b0; Ready = 1'b0;
      @(negedge clk);
      check("idle_state", StateP, 8'd0);

      // Reference conversion at 0xA5: 80,C0,A0,B0,A8,A4,A6,A5.
      convert(8'hA5, 1'b0);
      analog = 8'h10;
      @(negedge clk);
      @(negedge clk);
      check("idle_hold_code", SAROut, 8'hA5);
      check("idle_hold_result", Result, 8'hA5);

      convert(8'h00, 1'b0);
      convert(8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) convert(8'($urandom_range(0, 255)), 1'b0);
      convert(8'hFF, 1'b0);

      // Reset on cycle 4 of CONV aborts the conversion without Done.
      analog = 8'h5A;
      Start  = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      check("midrst_state", StateP, 8'd0);
      check("midrst_code", SAROut, 8'h00);
      check("midrst_result", Result, 8'h00);
      check("midrst_done", Done, 8'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen_done |= Done;
      end
      check("midrst_no_done", seen_done, 8'd0);
      check("midrst_idle", StateP, 8'd0);

`ifdef SAR_TRACK_EN
      // Ramp 0xA5 -> 0xA8 with Ready every 4th cycle.
      convert(8'hA5, 1'b1);
      n_inc = 0;
      n_dcr = 0;
      for (int c = 0; c < 12; c++) begin
         if (c % 4 == 3) track_cycle(1'b1, 8'(8'hA5 + 8'(c / 4 + 1)));
         else            track_cycle(1'b0, analog);
      end
      check("ramp_inc_count", 8'(n_inc), 8'd3);
      check("ramp_dcr_count", 8'(n_dcr), 8'd0);
      check("ramp_result", Result, 8'hA8);
      leave_track();

      // Saturation at the top rail.
      convert(8'hFF, 1'b1);
      n_inc = 0;
      for (int c = 0; c < 3; c++) track_cycle(1'b1, 8'hFF);
      check("sat_hi_inc_count", 8'(n_inc), 8'd0);
      leave_track();

      // Saturation at the bottom rail with comparator forced low.
      convert(8'h00, 1'b1);
      comp_force0 = 1'b1;
      n_dcr = 0;
      for (int c = 0; c < 3; c++) track_cycle(1'b1, 8'h00);
      check("sat_lo_dcr_count", 8'(n_dcr), 8'd0);
      comp_force0 = 1'b0;
      leave_track();

      // Random tracking against the model.
      convert(8'($urandom_range(0, 255)), 1'b1);
      for (int c = 0; c < 24; c++)
         track_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      leave_track();
`else
      // Tracking disabled: Track=1 still returns HOLD -> IDLE with no steps.
      convert(8'($urandom_range(0, 255)), 1'b1);
      Ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("notrk_state", StateP, 8'd0);
         check("notrk_incdcr", {Inc, Dcr}, 8'd0);
         check("notrk_code", SAROut, exp_sar);
      end
      Track = 1'b0;
      Ready = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
